// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
// Holds default geometry, forward-select encodings and writer-entry field layout.
package fwd_hazard_unit_pkg;

  // Default geometry of the unit.
  localparam int unsigned NSRC     = 2;
  localparam int unsigned AW       = 5;
  localparam int unsigned NSTG     = 3;
  localparam int unsigned LOAD_LAT = 1;
  localparam int unsigned SELW     = 2;

  // Forward-select encodings: 0 is the register file, k is the stage-k result.
  localparam int unsigned FW_SEL_REGFILE = 0;
  localparam int unsigned FW_SEL_EX      = 1;
  localparam int unsigned FW_SEL_MEM     = 2;
  localparam int unsigned FW_SEL_WB      = 3;

  // Writer entry layout {we, load, rd}: rd in the low AW bits, then load, then we.
  function automatic int unsigned ent_w(input int unsigned aw);
    return aw + 2;
  endfunction

  function automatic int unsigned ent_rd_lsb(input int unsigned aw);
    return 0 * aw;
  endfunction

  function automatic int unsigned ent_ld_bit(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned ent_we_bit(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side connection of the forwarding / hazard unit.
// master: the ID stage driving instruction fields; slave: the hazard unit.
interface fwd_hazard_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned P_NSRC = NSRC,
  parameter int unsigned P_AW   = AW,
  parameter int unsigned P_SELW = SELW
);

  logic                     id_valid_i;
  logic [P_NSRC*P_AW-1:0]   id_rs_i;
  logic [P_AW-1:0]          id_rd_i;
  logic                     id_we_i;
  logic                     id_load_i;
  logic                     flush_i;
  logic                     stall_o;
  logic [P_NSRC*P_SELW-1:0] id_fw_o;
  logic [P_NSRC*P_SELW-1:0] ex_fw_o;

  modport master (
    output id_valid_i, id_rs_i, id_rd_i, id_we_i, id_load_i, flush_i,
    input  stall_o, id_fw_o, ex_fw_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rd_i, id_we_i, id_load_i, flush_i,
    output stall_o, id_fw_o, ex_fw_o
  );

endinterface

// File: rtl/fwd_hazard_unit_match_node.sv
// One source-operand comparator against the flattened writer pipe.
// Returns the youngest matching stage in KMIN..KMAX and whether a not-yet-ready
// load (stage <= LOAD_LAT) writes this source.
module fwd_match_node
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned P_AW       = AW,
  parameter int unsigned P_NSTG     = NSTG,
  parameter int unsigned P_LOAD_LAT = LOAD_LAT,
  parameter int unsigned P_SELW     = SELW,
  parameter int unsigned KMIN       = 1,
  parameter int unsigned KMAX       = NSTG - 1
) (
  input  logic [P_AW-1:0]                src,
  input  logic [P_NSTG*ent_w(P_AW)-1:0]  pipe,
  output logic [P_SELW-1:0]              sel,
  output logic                           load_hit
);

  localparam int unsigned EW     = ent_w(P_AW);
  localparam int unsigned RD_LSB = ent_rd_lsb(P_AW);
  localparam int unsigned LD_BIT = ent_ld_bit(P_AW);
  localparam int unsigned WE_BIT = ent_we_bit(P_AW);

  logic [P_NSTG-1:0] hit;
  logic [P_NSTG-1:0] is_load;

  // Per-stage match; register 0 never matches.
  for (genvar k = 0; k < int'(P_NSTG); k++) begin : g_stg
    assign hit[k]     = pipe[k*EW + WE_BIT]
                        && (pipe[k*EW + RD_LSB +: P_AW] == src)
                        && (src != '0);
    assign is_load[k] = pipe[k*EW + LD_BIT];
  end

  // Scan oldest to youngest so the youngest eligible match wins.
  always_comb begin
    sel      = P_SELW'(FW_SEL_REGFILE);
    load_hit = 1'b0;
    for (int k = int'(P_NSTG) - 1; k >= 0; k--) begin
      if (hit[k] && (k + 1 >= int'(KMIN)) && (k + 1 <= int'(KMAX))) begin
        sel = P_SELW'(k + 1);
      end
      if (hit[k] && is_load[k] && (k + 1 <= int'(P_LOAD_LAT))) begin
        load_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the mips789 core.
// Tracks in-flight writers in an NSTG-deep shift pipe (stage 1 = EX), produces
// decode- and ALU-stage forward selects and the decode stall.
// Build option: define FWD_WB_BYPASS_EN to let the WB stage be a forward source
// (register file without write-through); otherwise WB is never selected.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned P_NSRC     = NSRC,
  parameter int unsigned P_AW       = AW,
  parameter int unsigned P_NSTG     = NSTG,
  parameter int unsigned P_LOAD_LAT = LOAD_LAT,
  parameter int unsigned P_SELW     = SELW
) (
  input  logic         clk,
  input  logic         rst,
  fwd_hazard_if.slave  hz
);

`ifdef FWD_WB_BYPASS_EN
  localparam int unsigned KMAX = P_NSTG;
`else
  localparam int unsigned KMAX = P_NSTG - 1;
`endif

  localparam int unsigned EW = ent_w(P_AW);
  localparam int unsigned PW = P_NSTG * EW;
  localparam int unsigned SW = P_NSRC * P_AW;
  localparam int unsigned FW = P_NSRC * P_SELW;

  logic [PW-1:0]     pipe_q;
  logic [SW-1:0]     ex_src_q;
  logic [FW-1:0]     id_sel;
  logic [FW-1:0]     ex_sel;
  logic [FW-1:0]     ex_fw;
  logic [P_NSRC-1:0] id_load_hit;
  logic [P_NSRC-1:0] ex_load_hit;
  logic              raw_hazard;
  logic              stall;
  logic              bubble;
  logic [EW-1:0]     s1_next;

  // Comparators: decode channels may forward from EX, ALU channels from MEM onward.
  for (genvar c = 0; c < int'(P_NSRC); c++) begin : g_ch
    fwd_match_node #(
      .P_AW(P_AW), .P_NSTG(P_NSTG), .P_LOAD_LAT(P_LOAD_LAT), .P_SELW(P_SELW),
      .KMIN(1), .KMAX(KMAX)
    ) u_id_node (
      .src      (hz.id_rs_i[c*P_AW +: P_AW]),
      .pipe     (pipe_q),
      .sel      (id_sel[c*P_SELW +: P_SELW]),
      .load_hit (id_load_hit[c])
    );

    fwd_match_node #(
      .P_AW(P_AW), .P_NSTG(P_NSTG), .P_LOAD_LAT(P_LOAD_LAT), .P_SELW(P_SELW),
      .KMIN(2), .KMAX(KMAX)
    ) u_ex_node (
      .src      (ex_src_q[c*P_AW +: P_AW]),
      .pipe     (pipe_q),
      .sel      (ex_sel[c*P_SELW +: P_SELW]),
      .load_hit (ex_load_hit[c])
    );

    // An ALU select never points at a load whose data is not ready yet.
    assign ex_fw[c*P_SELW +: P_SELW] = ex_load_hit[c] ? '0 : ex_sel[c*P_SELW +: P_SELW];
  end

  // Load-use detection; a flush kills the instruction so it never stalls.
  always_comb begin
    raw_hazard = |id_load_hit;
    stall      = hz.id_valid_i && !hz.flush_i && raw_hazard;
    bubble     = stall || hz.flush_i;
    s1_next    = bubble ? '0
                        : {hz.id_we_i & hz.id_valid_i, hz.id_load_i, hz.id_rd_i};
  end

  assign hz.stall_o = stall;
  assign hz.id_fw_o = raw_hazard ? '0 : id_sel;
  assign hz.ex_fw_o = ex_fw;

  // Writer pipe shifts one stage per clock; stage 1 sits in the low bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q   <= '0;
      ex_src_q <= '0;
    end else begin
      pipe_q   <= {pipe_q[PW-EW-1:0], s1_next};
      ex_src_q <= bubble ? '0 : hz.id_rs_i;
    end
  end

endmodule
